// File: rtl/pong_score_overlay.sv
// Score overlay stage: regenerates pixel coordinates from the syncs and draws two bitmap digits.
// Optional macro SCORE_BLINK_EN makes a newly changed digit blink for a number of frames.
module pong_score_overlay #(
    parameter int unsigned TOTAL_COLS  = 800,
    parameter int unsigned TOTAL_ROWS  = 525,
    parameter int unsigned P1_DIGIT_X  = 288,
    parameter int unsigned P2_DIGIT_X  = 340,
    parameter int unsigned DIGIT_Y     = 16,
    parameter int unsigned SCALE_LOG2  = 2,
    parameter logic [11:0] DIGIT_COLOR = 12'hFFF
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_HSync,
    input  logic       i_VSync,
    input  logic [3:0] i_Red_Video,
    input  logic [3:0] i_Grn_Video,
    input  logic [3:0] i_Blu_Video,
    input  logic [3:0] i_P1_Score,
    input  logic [3:0] i_P2_Score,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [3:0] o_Red_Video,
    output logic [3:0] o_Grn_Video,
    output logic [3:0] o_Blu_Video
);

    localparam int unsigned CW    = $clog2(TOTAL_COLS);
    localparam int unsigned RW    = $clog2(TOTAL_ROWS);
    localparam int unsigned BOX_W = 3 << SCALE_LOG2;
    localparam int unsigned BOX_H = 5 << SCALE_LOG2;

    logic          hs_q, vs_q;
    logic [11:0]   rgb_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [3:0]    p1_shadow_q, p2_shadow_q;
    logic          frame_start;
    logic          show1, show2;
    logic          lit1, lit2;

    // Font rows packed top row first: {row0, row1, row2, row3, row4}.
    function automatic logic [14:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = {3'd7, 3'd5, 3'd5, 3'd5, 3'd7};
            4'd1:    font = {3'd2, 3'd6, 3'd2, 3'd2, 3'd7};
            4'd2:    font = {3'd7, 3'd1, 3'd7, 3'd4, 3'd7};
            4'd3:    font = {3'd7, 3'd1, 3'd7, 3'd1, 3'd7};
            4'd4:    font = {3'd5, 3'd5, 3'd7, 3'd1, 3'd1};
            4'd5:    font = {3'd7, 3'd4, 3'd7, 3'd1, 3'd7};
            4'd6:    font = {3'd7, 3'd4, 3'd7, 3'd5, 3'd7};
            4'd7:    font = {3'd7, 3'd1, 3'd1, 3'd1, 3'd1};
            4'd8:    font = {3'd7, 3'd5, 3'd7, 3'd5, 3'd7};
            4'd9:    font = {3'd7, 3'd5, 3'd7, 3'd1, 3'd7};
            default: font = 15'd0;
        endcase
    endfunction

    function automatic logic digit_lit(input logic [3:0] d, input int unsigned col,
                                       input int unsigned row, input int unsigned x);
        logic [14:0] f;
        logic [2:0]  bits;
        int unsigned cx, cy;
        if (col < x || col >= x + BOX_W || row < DIGIT_Y || row >= DIGIT_Y + BOX_H) begin
            return 1'b0;
        end
        cx = (col - x) >> SCALE_LOG2;
        cy = (row - DIGIT_Y) >> SCALE_LOG2;
        f  = font(d);
        case (cy)
            0:       bits = f[14:12];
            1:       bits = f[11:9];
            2:       bits = f[8:6];
            3:       bits = f[5:3];
            default: bits = f[2:0];
        endcase
        // Leftmost cell sits in the MSB.
        return |(bits & (3'b100 >> cx));
    endfunction

    assign frame_start = i_VSync && !vs_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            rgb_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            p1_shadow_q <= '0;
            p2_shadow_q <= '0;
        end else begin
            hs_q  <= i_HSync;
            vs_q  <= i_VSync;
            rgb_q <= {i_Red_Video, i_Grn_Video, i_Blu_Video};
            if (frame_start) begin
                col_q       <= '0;
                row_q       <= '0;
                p1_shadow_q <= i_P1_Score;
                p2_shadow_q <= i_P2_Score;
            end else if (col_q == CW'(TOTAL_COLS - 1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(TOTAL_ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

`ifdef SCORE_BLINK_EN
    logic [5:0] blink1_q, blink2_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            blink1_q <= '0;
            blink2_q <= '0;
        end else if (frame_start) begin
            if (i_P1_Score != p1_shadow_q) blink1_q <= 6'd63;
            else if (blink1_q != 6'd0)     blink1_q <= blink1_q - 1'b1;
            if (i_P2_Score != p2_shadow_q) blink2_q <= 6'd63;
            else if (blink2_q != 6'd0)     blink2_q <= blink2_q - 1'b1;
        end
    end

    assign show1 = !((blink1_q != 6'd0) && blink1_q[3]);
    assign show2 = !((blink2_q != 6'd0) && blink2_q[3]);
`else
    assign show1 = 1'b1;
    assign show2 = 1'b1;
`endif

    always_comb begin
        lit1 = show1 && digit_lit(p1_shadow_q, 32'(col_q), 32'(row_q), P1_DIGIT_X);
        lit2 = show2 && digit_lit(p2_shadow_q, 32'(col_q), 32'(row_q), P2_DIGIT_X);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_HSync     <= 1'b0;
            o_VSync     <= 1'b0;
            o_Red_Video <= '0;
            o_Grn_Video <= '0;
            o_Blu_Video <= '0;
        end else begin
            o_HSync <= hs_q;
            o_VSync <= vs_q;
            {o_Red_Video, o_Grn_Video, o_Blu_Video} <= (lit1 || lit2) ? DIGIT_COLOR : rgb_q;
        end
    end

endmodule

// File: tb/tb_pong_score_overlay.sv
// Scoreboard bench for pong_score_overlay using a shortened frame (360x40) to keep runtime small.
module tb_pong_score_overlay;

    localparam int COLS = 360;
    localparam int ROWS = 40;
    localparam int NCK  = 26;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs, vs;
    logic [3:0] red, grn, blu, p1, p2;
    logic       o_hs, o_vs;
    logic [3:0] o_red, o_grn, o_blu;
    logic [13:0] dout;

    always #5 clk = ~clk;

    pong_score_overlay #(
        .TOTAL_COLS(COLS),
        .TOTAL_ROWS(ROWS)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_HSync(hs),
        .i_VSync(vs),
        .i_Red_Video(red),
        .i_Grn_Video(grn),
        .i_Blu_Video(blu),
        .i_P1_Score(p1),
        .i_P2_Score(p2),
        .o_HSync(o_hs),
        .o_VSync(o_vs),
        .o_Red_Video(o_red),
        .o_Grn_Video(o_grn),
        .o_Blu_Video(o_blu)
    );

    assign dout = {o_hs, o_vs, o_red, o_grn, o_blu};

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int          q_due[$];
    logic [13:0] q_exp[$];
    string       q_name[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    // Directed checks: frame, column, row, whether the pixel must be DIGIT_COLOR.
    int ck_fr  [NCK] = '{5'd0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                         1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3};
    int ck_col [NCK] = '{5, 100, 352, 356, 288, 292, 299, 287, 300, 288, 288, 340, 344,
                         340, 351, 292, 0, 99, 0, 292, 292, 288, 296, 288, 292, 344};
    int ck_row [NCK] = '{38, 10, 5, 5, 16, 20, 35, 16, 16, 15, 36, 16, 16,
                         20, 35, 24, 38, 39, 0, 24, 20, 28, 32, 16, 24, 16};
    bit ck_lit [NCK] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1,
                         1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    string ck_name [NCK] = '{"post_reset", "pass", "hs_fall", "hs_rise", "d0_tl", "d0_mid",
                             "d0_br", "d0_left", "d0_right", "d0_above", "d0_below",
                             "d1_tl", "d1_tm", "d1_r1", "d1_br", "d0_held", "vs_fall",
                             "vs_low", "vs_rise", "d4_mid", "d4_r1", "d4_r3", "d4_r4",
                             "blank_tl", "blank_mid", "p2_still"};

    int bcol, brow, fr;

    task automatic push(input int due, input logic [13:0] exp, input string name);
        q_due.push_back(due);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    task automatic step();
        hs  = !(bcol >= 352 && bcol < 356);
        vs  = (brow < ROWS - 2);
        red = 4'(bcol);
        grn = 4'(brow);
        blu = 4'h7;
        p2  = 4'd1;
        if (fr == 0 || (fr == 1 && brow < 20)) p1 = 4'd0;
        else if (fr == 1 || (fr == 2 && brow < 37)) p1 = 4'd4;
        else p1 = 4'd12;
        for (int i = 0; i < NCK; i++) begin
            if (fr == ck_fr[i] && bcol == ck_col[i] && brow == ck_row[i])
                push(edge_cnt + 2, {hs, vs, ck_lit[i] ? 12'hFFF : {red, grn, blu}}, ck_name[i]);
        end
        @(posedge clk);
        #1;
        bcol++;
        if (bcol == COLS) begin
            bcol = 0;
            brow++;
            if (brow == ROWS) begin
                brow = 0;
                fr++;
            end
        end
    endtask

    always @(negedge clk) begin
        while (q_due.size() > 0 && q_due[0] <= edge_cnt) begin
            n_cmp++;
            if (q_due[0] != edge_cnt || dout !== q_exp[0]) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h (due %0d, now %0d)",
                         q_name[0], dout, q_exp[0], q_due[0], edge_cnt);
            end
            void'(q_due.pop_front());
            void'(q_exp.pop_front());
            void'(q_name.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        hs  = 1'b1;
        vs  = 1'b1;
        red = 4'hF;
        grn = 4'hF;
        blu = 4'hF;
        p1  = 4'd9;
        p2  = 4'd9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            push(edge_cnt, 14'd0, "reset_hold");
        end
        rst  = 1'b0;
        bcol = 0;
        brow = ROWS - 2;
        fr   = 0;
        while (fr < 4) step();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        // Mid-cycle assertion: outputs must clear before the next clock edge.
        rst = 1'b1;
        push(edge_cnt, 14'd0, "rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        if (q_due.size() > 0) begin
            $display("FAIL drain: got %0d unchecked entries, expected 0", q_due.size());
            n_cmp  += q_due.size();
            n_fail += q_due.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
